// File: rtl/asmi_pkg.sv
// Shared definitions for the EPCS/ASMI flash access path, used by both the
// flash reader and the flash writer.
package asmi_pkg;

  localparam logic [23:0] EPCS_IMAGE_BASE = 24'h100000;
  localparam int          EPCS_PAGE_BYTES = 256;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    OPEN     = 3'd2,
    STREAM   = 3'd3,
    CLOSE    = 3'd4,
    WAIT_ACK = 3'd5,
    DONE     = 3'd6
  } asmi_state_t;

  // The PC sends bytes LSB-first relative to the flash bit order.
  function automatic logic [7:0] bit_reverse(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/asmi_flag_handshake.sv
// Set/hold-until-ACK flag: rises on set, stays high until ack is seen while
// high. Set wins over ack, so the flag is always visible for at least one clock.
module asmi_flag_handshake (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic ack,
  output logic flag
);

  always_ff @(posedge clock) begin
    if (reset)    flag <= 1'b0;
    else if (set) flag <= 1'b1;
    else if (ack) flag <= 1'b0;
  end

endmodule

// File: rtl/asmi_flash_reader.sv
// Reads num_blocks flash pages over ASMI and streams them bit-reversed into the
// Tx FIFO. Optional running byte checksum port: define ASMI_READER_CHECKSUM_EN.
module asmi_flash_reader
  import asmi_pkg::*;
#(
  parameter logic [23:0] START_ADDR     = EPCS_IMAGE_BASE,
  parameter int          PAGE_BYTES     = EPCS_PAGE_BYTES,
  parameter int          TX_FIFO_DEPTH  = 1024,
  parameter int          TIMEOUT_CYCLES = 2000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_req,
  output logic        read_ACK,
  input  logic [13:0] num_blocks,
  output logic [23:0] asmi_addr,
  output logic        asmi_rden,
  output logic        asmi_read,
  input  logic [7:0]  asmi_dataout,
  input  logic        asmi_data_valid,
  input  logic        asmi_busy,
  input  logic [9:0]  tx_used,
  output logic        tx_wrreq,
  output logic [7:0]  tx_data,
  output logic        send_block,
  input  logic        send_block_ACK,
  output logic        read_done,
  input  logic        read_done_ACK,
  output logic        read_error,
`ifdef ASMI_READER_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output asmi_state_t dbg_state
);

  localparam logic [10:0] SPACE_LIMIT  = 11'(TX_FIFO_DEPTH - PAGE_BYTES);
  localparam logic [8:0]  LAST_BYTE    = 9'(PAGE_BYTES - 1);
  localparam logic [20:0] TIMEOUT_LAST = 21'(TIMEOUT_CYCLES - 1);

  asmi_state_t state, state_nxt;
  logic [13:0] blocks_target, blocks_read;
  logic [8:0]  byte_count;
  logic [20:0] timeout_cnt;
  logic        accept, space_ok, page_write, last_byte, timed_out;
  logic        start_page, enter_done;

  // Handshake contract: read_ACK, asmi_read are 1-clock pulses; send_block and
  // read_done are held until their ACK is seen high while the flag is high.
  assign accept     = (state == IDLE) && read_req && !asmi_busy;
  assign space_ok   = ({1'b0, tx_used} <= SPACE_LIMIT) && !asmi_busy;
  assign page_write = (state == STREAM) && asmi_data_valid;
  assign last_byte  = page_write && (byte_count == LAST_BYTE);
  assign timed_out  = (state == STREAM) && !last_byte && (timeout_cnt == TIMEOUT_LAST);
  assign start_page = (state == CHECK) && (state_nxt == OPEN);
  assign enter_done = (state_nxt == DONE) && (state != DONE);
  assign dbg_state  = state;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = CHECK;
      CHECK: begin
        if (blocks_read == blocks_target) state_nxt = DONE;
        else if (space_ok)                state_nxt = OPEN;
      end
      OPEN:     state_nxt = STREAM;
      STREAM: begin
        if (last_byte)      state_nxt = CLOSE;
        else if (timed_out) state_nxt = DONE;
      end
      CLOSE:    state_nxt = WAIT_ACK;
      WAIT_ACK: if (send_block && send_block_ACK) state_nxt = CHECK;
      DONE:     if (read_done && read_done_ACK) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_ACK      <= 1'b0;
      asmi_addr     <= START_ADDR;
      asmi_rden     <= 1'b0;
      asmi_read     <= 1'b0;
      tx_wrreq      <= 1'b0;
      tx_data       <= 8'h00;
      read_error    <= 1'b0;
      blocks_target <= 14'd0;
      blocks_read   <= 14'd0;
      byte_count    <= 9'd0;
      timeout_cnt   <= 21'd0;
    end else begin
      read_ACK  <= accept;
      asmi_read <= start_page;
      tx_wrreq  <= page_write;
      if (accept) begin
        blocks_target <= num_blocks;
        blocks_read   <= 14'd0;
        asmi_addr     <= START_ADDR;
        read_error    <= 1'b0;
      end
      if (start_page) asmi_rden <= 1'b1;
      else if (last_byte || timed_out) asmi_rden <= 1'b0;
      if (state == OPEN) begin
        byte_count  <= 9'd0;
        timeout_cnt <= 21'd0;
      end else if (state == STREAM) begin
        timeout_cnt <= timeout_cnt + 21'd1;
        if (page_write) begin
          tx_data    <= bit_reverse(asmi_dataout);
          byte_count <= byte_count + 9'd1;
        end
      end
      // Address wraps at 24 bits; the flash decoder handles aliasing.
      if (state == CLOSE) begin
        blocks_read <= blocks_read + 14'd1;
        asmi_addr   <= asmi_addr + 24'(PAGE_BYTES);
      end
      if (timed_out) read_error <= 1'b1;
    end
  end

  asmi_flag_handshake u_send_block_flag (
    .clock (clock),
    .reset (reset),
    .set   (state == CLOSE),
    .ack   (send_block_ACK && (state == WAIT_ACK)),
    .flag  (send_block)
  );

  asmi_flag_handshake u_read_done_flag (
    .clock (clock),
    .reset (reset),
    .set   (enter_done),
    .ack   (read_done_ACK && (state == DONE)),
    .flag  (read_done)
  );

`ifdef ASMI_READER_CHECKSUM_EN
  // Sums the bytes as written to the FIFO (post bit-reversal).
  always_ff @(posedge clock) begin
    if (reset || accept) checksum <= 16'h0000;
    else if (page_write) checksum <= checksum + {8'h00, bit_reverse(asmi_dataout)};
  end
`endif

endmodule

// File: doc/asmi_flash_reader.md
Name: asmi_flash_reader

Overview:
- Read-back counterpart of the EPCS flash programming path: reads pages from serial config flash via an ASMI read port and streams them to the Tx FIFO so the PC can verify a programmed image.
- Sits between the Rx command decoder (start/ack flags) and the Tx packet builder (FIFO, per-block handshake).
- Starts at START_ADDR and reads num_blocks pages of 256 bytes.
- Bytes are bit-reversed on output so the PC receives them in the same bit order it originally sent.

Parameters:
- START_ADDR, 24'h100000, first flash byte address read (upper 1 MB image region).
- PAGE_BYTES, 256, bytes per block; must be a power of 2.
- TX_FIFO_DEPTH, 1024, Tx FIFO depth in bytes; used for the space check.
- TIMEOUT_CYCLES, 2000000, maximum clocks waiting on ASMI data per page before abort.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- read_req  in  1  level from Rx decoder requesting a readback.
- read_ACK  out  1  high for 1 clock when read_req is accepted.
- num_blocks  in  14  pages to read; sampled at acceptance.
- asmi_addr  out  24  flash byte address.
- asmi_rden  out  1  ASMI read enable; held high for the whole page.
- asmi_read  out  1  1-clock pulse that latches asmi_addr and starts the read.
- asmi_dataout  in  8  flash byte, flash bit order.
- asmi_data_valid  in  1  asmi_dataout is valid this clock.
- asmi_busy  in  1  ASMI engine busy.
- tx_used  in  10  Tx FIFO fill level.
- tx_wrreq  out  1  Tx FIFO write strobe.
- tx_data  out  8  bit-reversed byte written to the FIFO.
- send_block  out  1  a full page is in the FIFO; held until send_block_ACK.
- send_block_ACK  in  1  Tx has seen send_block.
- read_done  out  1  readback finished; held until read_done_ACK.
- read_done_ACK  in  1  Tx has seen read_done.
- read_error  out  1  timeout abort flag; cleared on the next accepted request.

Behaviour:
- Reset values: all outputs 0. asmi_addr = START_ADDR. State IDLE. Internal counters 0.
- IDLE: on read_req && !asmi_busy, latch num_blocks, set address = START_ADDR, clear read_error, pulse read_ACK, go to CHECK. read_req while not in IDLE is ignored.
- CHECK:
  - If blocks_read == num_blocks → DONE. num_blocks = 0 therefore finishes with no flash access.
  - Else if tx_used <= TX_FIFO_DEPTH-PAGE_BYTES && !asmi_busy → OPEN.
  - Otherwise wait in CHECK.
- OPEN: asmi_rden = 1, asmi_read pulsed for 1 clock, byte_count = 0, timeout counter = 0 → STREAM.
- STREAM:
  - Each clock with asmi_data_valid: tx_wrreq = 1 in the same registered cycle; tx_data = reversed asmi_dataout (bit i ← bit 7-i); byte_count++.
  - The valid that brings byte_count to PAGE_BYTES → CLOSE.
  - valid arriving after the page is complete is discarded (no write).
  - Latency: asmi_data_valid to tx_wrreq is exactly 1 clock.
- CLOSE: asmi_rden = 0, blocks_read++, asmi_addr += PAGE_BYTES (24-bit wrap, no saturation), send_block = 1 → WAIT_ACK.
- WAIT_ACK: when send_block_ACK, send_block = 0 → CHECK. If send_block_ACK is already high on entry, the flag is still asserted for at least 1 clock.
- DONE: read_done = 1; on read_done_ACK clear read_done → IDLE. A read_req high in that same clock is not accepted until the next IDLE clock.
- Timeout: timeout counter reaching TIMEOUT_CYCLES in STREAM → asmi_rden = 0, read_error = 1, read_done = 1 → DONE. The partial page remains in the FIFO and no send_block is issued.
- Reset mid-operation: asmi_rden drops in the reset clock and there are no further FIFO writes. The Tx side discards partial data.
- Widths: blocks_read 14-bit, byte_count 9-bit (reaches 256), timeout counter 21-bit.

Optional Feature:
- Macro: ASMI_READER_CHECKSUM_EN.
- Enabled:
  - Extra port checksum (out, 16): running sum mod 2^16 of every written tx_data byte.
  - Cleared on request acceptance; valid and stable while read_done = 1.
- Disabled: port, adder and register are absent; all other behaviour is identical.

Decomposition:
- Shared package asmi_pkg holds:
  - state enum (IDLE, CHECK, OPEN, STREAM, CLOSE, WAIT_ACK, DONE);
  - EPCS_IMAGE_BASE = 24'h100000;
  - EPCS_PAGE_BYTES = 256;
  - a bit-reverse function reused by the flash writer.
- One sub-module is natural: asmi_flag_handshake, a set/hold-until-ACK flag instantiated for send_block and read_done.

Test Plan:
- Reset with read_req = 1 → all outputs 0, no read_ACK until reset is released; then read_ACK is a single 1-clock pulse.
- num_blocks = 2, ASMI model returns 8'h01 then incrementing bytes:
  - 512 tx_wrreq pulses; first tx_data = 8'h80;
  - asmi_addr 0x100000 then 0x100100;
  - two send_block/ACK exchanges, then read_done.
- tx_used = 800 (of 1024) → stays in CHECK, no asmi_read; drop tx_used to 768 → OPEN next clock.
- num_blocks = 0 → read_ACK then read_done with zero asmi_read pulses.
- ASMI stops after 100 valid bytes → after TIMEOUT_CYCLES read_error = 1, read_done = 1, asmi_rden = 0, 100 writes total.
- With ASMI_READER_CHECKSUM_EN, one page of all 8'hFF → checksum = 16'hFF00 at read_done.
